// File: rtl/gray_updown_counter.sv
// rtl/gray_updown_counter.sv - Gray-code up/down counter with clear, load, wrap/saturate and end-of-range flags
module gray_updown_counter #(
  parameter int WIDTH    = 4,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] gray_o,
  output logic [WIDTH-1:0] bin_o,
  output logic             wrap_o,
  output logic             at_max_o,
  output logic             at_min_o
);

  localparam logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_VAL = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_VAL  = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic             at_max_q, at_max_d;
  logic             at_min_q, at_min_d;
  logic [WIDTH-1:0] load_bin;

  // Gray-to-binary of the load value: each binary bit is the XOR of all Gray bits from the MSB down to it
  always_comb begin
    load_bin = ZERO_VAL;
    load_bin[WIDTH-1] = load_val_i[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      load_bin[i] = load_bin[i+1] ^ load_val_i[i];
    end
  end

  // Next binary count with clr > load > en priority; all outputs are derived from the next count so they register together
  always_comb begin
    b_d    = b_q;
    wrap_d = 1'b0;
    if (clr_i) begin
      b_d = ZERO_VAL;
    end else if (load_i) begin
      b_d = load_bin;
    end else if (en_i) begin
      if (dir_i) begin
        if (b_q != MAX_VAL) begin
          b_d = b_q + ONE_VAL;
        end else if (!SATURATE) begin
          b_d    = ZERO_VAL;
          wrap_d = 1'b1;
        end
      end else begin
        if (b_q != ZERO_VAL) begin
          b_d = b_q - ONE_VAL;
        end else if (!SATURATE) begin
          b_d    = MAX_VAL;
          wrap_d = 1'b1;
        end
      end
    end
    gray_d   = b_d ^ (b_d >> 1);
    at_max_d = (b_d == MAX_VAL);
    at_min_d = (b_d == ZERO_VAL);
  end

  // State and output registers; reset parks the counter at code 0
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      b_q      <= ZERO_VAL;
      gray_q   <= ZERO_VAL;
      wrap_q   <= 1'b0;
      at_max_q <= 1'b0;
      at_min_q <= 1'b1;
    end else begin
      b_q      <= b_d;
      gray_q   <= gray_d;
      wrap_q   <= wrap_d;
      at_max_q <= at_max_d;
      at_min_q <= at_min_d;
    end
  end

  assign gray_o   = gray_q;
  assign bin_o    = b_q;
  assign wrap_o   = wrap_q;
  assign at_max_o = at_max_q;
  assign at_min_o = at_min_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb/tb_gray_updown_counter.sv - scoreboard bench for gray_updown_counter
module tb_gray_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, dir = 1'b0, clr = 1'b0, load = 1'b0;
  logic [7:0] lv = 8'h00;

  logic [3:0] w_gray, w_bin, s_gray, s_bin;
  logic       w_wrap, w_max, w_min, s_wrap, s_max, s_min;
  logic [7:0] r_gray, r_bin;
  logic       r_wrap, r_max, r_min;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b0)) u_wrap (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .clr_i(clr), .load_i(load),
    .load_val_i(lv[3:0]), .gray_o(w_gray), .bin_o(w_bin), .wrap_o(w_wrap),
    .at_max_o(w_max), .at_min_o(w_min));

  gray_updown_counter #(.WIDTH(4), .SATURATE(1'b1)) u_sat (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .clr_i(clr), .load_i(load),
    .load_val_i(lv[3:0]), .gray_o(s_gray), .bin_o(s_bin), .wrap_o(s_wrap),
    .at_max_o(s_max), .at_min_o(s_min));

  gray_updown_counter #(.WIDTH(8), .SATURATE(1'b0)) u_rnd (
    .clk_i(clk), .rst_i(rst), .en_i(en), .dir_i(dir), .clr_i(clr), .load_i(load),
    .load_val_i(lv), .gray_o(r_gray), .bin_o(r_bin), .wrap_o(r_wrap),
    .at_max_o(r_max), .at_min_o(r_min));

  typedef struct {
    int         id;
    int         tag;
    logic [7:0] gray;
    logic [7:0] bin;
    logic       wrap;
    logic       amax;
    logic       amin;
    logic       en_only;
    logic       changed;
  } exp_t;

  exp_t q[$];

  // 4-bit Gray sequence written out by hand, indexed by binary value
  logic [3:0] gseq [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                            4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};

  task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s tag=%0d actual=%0h expected=%0h", nm, tag, act, exp);
    end
  endtask

  function automatic logic [7:0] g2b(input logic [7:0] g);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 8; i++) b = b ^ (g >> i);
    return b;
  endfunction

  task automatic drive(input int id, input int tag, input logic e, input logic d, input logic c,
                       input logic l, input logic [7:0] v, input logic [7:0] eg, input logic [7:0] eb,
                       input logic ew, input logic emax, input logic emin);
    exp_t x;
    @(negedge clk);
    en = e; dir = d; clr = c; load = l; lv = v;
    x.id = id; x.tag = tag; x.gray = eg; x.bin = eb; x.wrap = ew; x.amax = emax; x.amin = emin;
    x.en_only = e & ~c & ~l; x.changed = 1'b0;
    q.push_back(x);
  endtask

  // Monitor: pops one expectation per edge it was issued for and checks the addressed instance
  logic [7:0] rnd_prev = 8'h00;
  always @(posedge clk) begin
    exp_t x;
    logic [7:0] ag, ab;
    logic aw, amx, amn;
    #2;
    if (q.size() > 0) begin
      x = q.pop_front();
      case (x.id)
        0:       begin ag = {4'h0, w_gray}; ab = {4'h0, w_bin}; aw = w_wrap; amx = w_max; amn = w_min; end
        1:       begin ag = {4'h0, s_gray}; ab = {4'h0, s_bin}; aw = s_wrap; amx = s_max; amn = s_min; end
        default: begin ag = r_gray; ab = r_bin; aw = r_wrap; amx = r_max; amn = r_min; end
      endcase
      chk("gray", x.tag, 32'(ag), 32'(x.gray));
      chk("bin", x.tag, 32'(ab), 32'(x.bin));
      chk("wrap", x.tag, 32'(aw), 32'(x.wrap));
      chk("at_max", x.tag, 32'(amx), 32'(x.amax));
      chk("at_min", x.tag, 32'(amn), 32'(x.amin));
      if (x.id == 2) begin
        chk("bin_decode", x.tag, 32'(ab), 32'(g2b(ag)));
        if (x.en_only && x.changed)
          chk("one_bit_step", x.tag, 32'($countones(ag ^ rnd_prev)), 32'd1);
        rnd_prev = ag;
      end
    end
  end

  task automatic idle_reset();
    @(negedge clk);
    en = 0; dir = 0; clr = 0; load = 0; rst = 0;
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    logic [7:0] m, nm;
    logic       ew, e, d, c, l;
    logic [7:0] v;
    int         b;

    // Reset values
    #12;
    chk("rst_gray", 0, 32'(w_gray), 32'h0);
    chk("rst_bin", 0, 32'(w_bin), 32'h0);
    chk("rst_wrap", 0, 32'(w_wrap), 32'h0);
    chk("rst_min", 0, 32'(w_min), 32'h1);
    chk("rst_max", 0, 32'(w_max), 32'h0);
    @(negedge clk);
    rst = 1;

    // Up count through a full wrap
    for (int k = 1; k <= 17; k++) begin
      b = k % 16;
      drive(0, 100 + k, 1, 1, 0, 0, 8'h00, {4'h0, gseq[b]}, 8'(b), k == 16, b == 15, b == 0);
    end

    // Down wrap from reset
    idle_reset();
    drive(0, 200, 1, 0, 0, 0, 8'h00, 8'b1000, 8'd15, 1, 1, 0);
    drive(0, 201, 1, 0, 0, 0, 8'h00, 8'b1001, 8'd14, 0, 0, 0);

    // Priority: clr over load over en; a discarded step never wraps
    drive(0, 400, 0, 0, 0, 1, 8'b0101, 8'b0101, 8'd6, 0, 0, 0);
    drive(0, 401, 1, 1, 1, 1, 8'b0101, 8'b0000, 8'd0, 0, 0, 1);
    drive(0, 402, 1, 1, 0, 1, 8'b1110, 8'b1110, 8'd11, 0, 0, 0);
    drive(0, 403, 0, 0, 0, 1, 8'b1000, 8'b1000, 8'd15, 0, 1, 0);
    drive(0, 404, 1, 1, 0, 1, 8'b1000, 8'b1000, 8'd15, 0, 1, 0);
    drive(0, 405, 1, 1, 1, 0, 8'b0000, 8'b0000, 8'd0, 0, 0, 1);

    // Mid-run asynchronous reset, then direction reversal every cycle
    for (int k = 1; k <= 4; k++)
      drive(0, 500 + k, 1, 1, 0, 0, 8'h00, {4'h0, gseq[k]}, 8'(k), 0, 0, 0);
    @(negedge clk);
    en = 0;
    rst = 0;
    #1;
    chk("async_rst_gray", 510, 32'(w_gray), 32'h0);
    chk("async_rst_wrap", 510, 32'(w_wrap), 32'h0);
    chk("async_rst_min", 510, 32'(w_min), 32'h1);
    #1;
    rst = 1;
    for (int k = 0; k < 4; k++)
      drive(0, 520 + k, 1, (k % 2) == 0, 0, 0, 8'h00, {7'h0, (k % 2) == 0}, {7'h0, (k % 2) == 0}, 0, 0, (k % 2) == 1);

    // Saturate mode on the saturating instance
    drive(1, 300, 0, 0, 0, 1, 8'b1000, 8'b1000, 8'd15, 0, 1, 0);
    for (int k = 0; k < 3; k++)
      drive(1, 310 + k, 1, 1, 0, 0, 8'h00, 8'b1000, 8'd15, 0, 1, 0);
    for (int k = 1; k <= 16; k++) begin
      b = (k <= 15) ? 15 - k : 0;
      drive(1, 320 + k, 1, 0, 0, 0, 8'h00, {4'h0, gseq[b]}, 8'(b), 0, 0, b == 0);
    end

    // Random traffic on the 8-bit instance against a reference count
    idle_reset();
    m = 8'h00;
    for (int k = 0; k < 10000; k++) begin
      exp_t x;
      c = ($urandom_range(0, 99) < 3);
      l = ($urandom_range(0, 99) < 4);
      e = ($urandom_range(0, 99) < 80);
      d = $urandom_range(0, 1);
      v = 8'($urandom);
      ew = 1'b0;
      if (c) nm = 8'h00;
      else if (l) nm = g2b(v);
      else if (e && d) begin
        nm = m + 8'd1;
        ew = (m == 8'hFF);
      end else if (e) begin
        nm = m - 8'd1;
        ew = (m == 8'h00);
      end else nm = m;
      @(negedge clk);
      en = e; dir = d; clr = c; load = l; lv = v;
      x.id = 2; x.tag = 600000 + k; x.gray = nm ^ (nm >> 1); x.bin = nm; x.wrap = ew;
      x.amax = (nm == 8'hFF); x.amin = (nm == 8'h00);
      x.en_only = e & ~c & ~l; x.changed = (nm != m);
      q.push_back(x);
      m = nm;
    end

    @(negedge clk);
    en = 0; clr = 0; load = 0;
    repeat (3) @(negedge clk);
    if (q.size() != 0) chk("queue_drained", 0, 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
